// File: rtl/bcd_serial_rx_pkg.sv
// Shared definitions for the BCD serial receiver: FSM encoding, frame length, BCD limit.
// Frame length grows to 5 bits (4 data + odd parity) when BCD_RX_PARITY_EN is defined.
package bcd_serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

`ifdef BCD_RX_PARITY_EN
    localparam int FRAME_BITS = 5;
`else
    localparam int FRAME_BITS = 4;
`endif

    localparam int BCNT_W = 3;

    function automatic logic is_bcd(input logic [3:0] v);
        return (v <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_rx_shift_reg.sv
// Serial-in shift register with bit counter; clear and load in the same cycle
// restarts the frame with the incoming bit as its first bit.
module bcd_shift_reg #(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load_en,
    input  logic          bit_in,
    output logic [W-1:0]  data,
    output logic [CW-1:0] bit_cnt
);

    logic [W-1:0]  data_base;
    logic [CW-1:0] cnt_base;

    assign data_base = clr ? '0 : data;
    assign cnt_base  = clr ? '0 : bit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (load_en) begin
            // MSB-first shifts toward bit W-1 so the first bit ends up on top
            if (MSB_FIRST)
                data <= {data_base[W-2:0], bit_in};
            else
                data <= {bit_in, data_base[W-1:1]};
            bit_cnt <= cnt_base + CW'(1);
        end else begin
            data    <= data_base;
            bit_cnt <= cnt_base;
        end
    end

endmodule

// File: rtl/bcd_serial_rx.sv
// Bit-serial BCD digit receiver feeding the divby3or5 checker; rejects codes 10-15.
// Define BCD_RX_PARITY_EN for 5-bit frames carrying a trailing odd-parity bit.
module bcd_serial_rx
    import bcd_serial_rx_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             abort,
    output logic [3:0]       bcd,
    output logic             bcd_valid,
    output logic             bcd_err,
    output logic             busy,
    output logic [CNT_W-1:0] dig_cnt
);

    localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(FRAME_BITS - 1);

    rx_state_e               state_q, state_d;
    logic                    sr_clr, sr_load, do_check;
    logic [FRAME_BITS-1:0]   frame;
    logic [BCNT_W-1:0]       bit_cnt;
    logic [3:0]              digit;
    logic                    frame_ok;

    bcd_shift_reg #(
        .W         (FRAME_BITS),
        .MSB_FIRST (MSB_FIRST),
        .CW        (BCNT_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sr_clr),
        .load_en (sr_load),
        .bit_in  (s_in),
        .data    (frame),
        .bit_cnt (bit_cnt)
    );

`ifdef BCD_RX_PARITY_EN
    // Parity is the last bit received, so it sits at the opposite end from the first data bit
    assign digit    = MSB_FIRST ? frame[4:1] : frame[3:0];
    assign frame_ok = (^frame) && is_bcd(digit);
`else
    assign digit    = frame;
    assign frame_ok = is_bcd(digit);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        sr_clr   = 1'b0;
        sr_load  = 1'b0;
        do_check = 1'b0;
        if (abort) begin
            state_d = IDLE;
            sr_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        sr_load = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (s_valid) begin
                        sr_load = 1'b1;
                        if (bit_cnt == LAST_CNT)
                            state_d = CHECK;
                    end
                end
                CHECK: begin
                    // A bit arriving now starts the next frame rather than being dropped
                    do_check = 1'b1;
                    sr_clr   = 1'b1;
                    if (s_valid) begin
                        sr_load = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sr_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd       <= 4'd0;
            bcd_valid <= 1'b0;
            bcd_err   <= 1'b0;
            dig_cnt   <= '0;
        end else begin
            bcd_valid <= 1'b0;
            bcd_err   <= 1'b0;
            if (do_check) begin
                if (frame_ok) begin
                    bcd       <= digit;
                    bcd_valid <= 1'b1;
                    if (dig_cnt != '1)
                        dig_cnt <= dig_cnt + CNT_W'(1);
                end else begin
                    bcd_err <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bcd_serial_rx.sv
// Directed bench for bcd_serial_rx: MSB-first instance with 8-bit counter plus an
// LSB-first instance with a 2-bit counter sharing the same serial stream.
module tb_bcd_serial_rx;

`ifdef BCD_RX_PARITY_EN
    localparam int FB = 5;
`else
    localparam int FB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n, s_in, s_valid, abort;
    logic [3:0] bcd, bcd_l;
    logic       bcd_valid, bcd_err, busy;
    logic       bcd_valid_l, bcd_err_l, busy_l;
    logic [7:0] dig_cnt;
    logic [1:0] dig_cnt_l;

    int n_checks = 0;
    int n_fail   = 0;
    int v_pulses = 0;
    int e_pulses = 0;
    int both     = 0;

    bcd_serial_rx #(.MSB_FIRST(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .abort(abort),
        .bcd(bcd), .bcd_valid(bcd_valid), .bcd_err(bcd_err), .busy(busy), .dig_cnt(dig_cnt)
    );

    bcd_serial_rx #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .abort(abort),
        .bcd(bcd_l), .bcd_valid(bcd_valid_l), .bcd_err(bcd_err_l), .busy(busy_l), .dig_cnt(dig_cnt_l)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bcd_valid) v_pulses++;
        if (bcd_err) e_pulses++;
        if (bcd_valid && bcd_err) both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of a frame, listed in transmit order: d[3] first, then optional odd parity
    function automatic logic frame_bit(input logic [3:0] d, input int i, input logic bad_par);
        if (i < 4) return d[3-i];
        return ~(^d) ^ bad_par;
    endfunction

    task automatic drive_bits(input logic [3:0] d, input int first, input logic bad_par);
        for (int i = first; i < FB; i++) begin
            s_in    = frame_bit(d, i, bad_par);
            s_valid = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_in = 1'b0; s_valid = 1'b0; abort = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bcd !== 4'd0) begin n_fail++; $display("FAIL reset_bcd: got %0d expected 0", bcd); end
        n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bcd_valid); end
        n_checks++; if (bcd_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bcd_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dig_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dig_cnt); end
    endtask

    task automatic test_basic();
        int vp0 = v_pulses;
        s_valid = 1'b1;
        for (int i = 0; i < FB; i++) begin
            s_in = frame_bit(4'd7, i, 1'b0);
            tick();
            if (i == 0) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
            end
        end
        s_valid = 1'b0;
        n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bcd_valid); end
        tick();
        n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", bcd_valid); end
        n_checks++; if (bcd !== 4'd7) begin n_fail++; $display("FAIL basic_bcd: got %0d expected 7", bcd); end
        n_checks++; if (dig_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 1", dig_cnt); end
        tick();
        n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_end: got %b expected 0", bcd_valid); end
        n_checks++; if (v_pulses - vp0 !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 1", v_pulses - vp0); end
    endtask

    task automatic test_bcd_err();
        int ep0 = e_pulses;
        drive_bits(4'd12, 0, 1'b0);
        s_valid = 1'b0;
        tick();
        n_checks++; if (bcd_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b expected 1", bcd_err); end
        n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL err_valid: got %b expected 0", bcd_valid); end
        n_checks++; if (bcd !== 4'd7) begin n_fail++; $display("FAIL err_bcd_hold: got %0d expected 7", bcd); end
        n_checks++; if (dig_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt: got %0d expected 1", dig_cnt); end
        tick();
        n_checks++; if (e_pulses - ep0 !== 1) begin n_fail++; $display("FAIL err_pulses: got %0d expected 1", e_pulses - ep0); end
    endtask

    task automatic test_back_to_back();
        int vp0 = v_pulses;
        drive_bits(4'd9, 0, 1'b0);
        s_in = frame_bit(4'd0, 0, 1'b0);
        tick();
        n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b expected 1", bcd_valid); end
        n_checks++; if (bcd !== 4'd9) begin n_fail++; $display("FAIL b2b_bcd1: got %0d expected 9", bcd); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        drive_bits(4'd0, 1, 1'b0);
        s_valid = 1'b0;
        tick();
        n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b expected 1", bcd_valid); end
        n_checks++; if (bcd !== 4'd0) begin n_fail++; $display("FAIL b2b_bcd2: got %0d expected 0", bcd); end
        n_checks++; if (dig_cnt !== 8'd3) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 3", dig_cnt); end
        tick();
        n_checks++; if (v_pulses - vp0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", v_pulses - vp0); end
    endtask

    task automatic test_abort();
        int vp0 = v_pulses;
        int ep0 = e_pulses;
        s_valid = 1'b1;
        s_in = 1'b1; tick();
        s_in = 1'b0; tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pre: got %b expected 1", busy); end
        abort = 1'b1; s_in = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_drop: got %b expected 0", busy); end
        drive_bits(4'd5, 0, 1'b0);
        s_valid = 1'b0;
        tick();
        n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid: got %b expected 1", bcd_valid); end
        n_checks++; if (bcd !== 4'd5) begin n_fail++; $display("FAIL abort_bcd: got %0d expected 5", bcd); end
        tick();
        drive_bits(4'd3, 0, 1'b0);
        s_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_check_valid: got %b expected 0", bcd_valid); end
        n_checks++; if (bcd !== 4'd5) begin n_fail++; $display("FAIL abort_check_bcd: got %0d expected 5", bcd); end
        tick();
        n_checks++; if (v_pulses - vp0 !== 1) begin n_fail++; $display("FAIL abort_vpulses: got %0d expected 1", v_pulses - vp0); end
        n_checks++; if (e_pulses - ep0 !== 0) begin n_fail++; $display("FAIL abort_epulses: got %0d expected 0", e_pulses - ep0); end
        n_checks++; if (dig_cnt !== 8'd4) begin n_fail++; $display("FAIL abort_cnt: got %0d expected 4", dig_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int vp0, ep0;
        s_valid = 1'b1; s_in = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre: got %b expected 1", busy); end
        s_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (dig_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", dig_cnt); end
        n_checks++; if (bcd !== 4'd0) begin n_fail++; $display("FAIL rstmid_bcd: got %0d expected 0", bcd); end
        vp0 = v_pulses; ep0 = e_pulses;
        drive_bits(4'd3, 0, 1'b0);
        s_valid = 1'b0;
        tick();
        n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 1", bcd_valid); end
        n_checks++; if (bcd !== 4'd3) begin n_fail++; $display("FAIL rstmid_bcd3: got %0d expected 3", bcd); end
        n_checks++; if (dig_cnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_cnt1: got %0d expected 1", dig_cnt); end
        tick();
        n_checks++; if (v_pulses - vp0 !== 1) begin n_fail++; $display("FAIL rstmid_vpulses: got %0d expected 1", v_pulses - vp0); end
        n_checks++; if (e_pulses - ep0 !== 0) begin n_fail++; $display("FAIL rstmid_epulses: got %0d expected 0", e_pulses - ep0); end
    endtask

`ifdef BCD_RX_PARITY_EN
    task automatic test_parity();
        drive_bits(4'd6, 0, 1'b0);
        s_valid = 1'b0;
        tick();
        n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL par_good_valid: got %b expected 1", bcd_valid); end
        n_checks++; if (bcd !== 4'd6) begin n_fail++; $display("FAIL par_good_bcd: got %0d expected 6", bcd); end
        tick();
        drive_bits(4'd6, 0, 1'b1);
        s_valid = 1'b0;
        tick();
        n_checks++; if (bcd_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_err: got %b expected 1", bcd_err); end
        n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL par_bad_valid: got %b expected 0", bcd_valid); end
        n_checks++; if (dig_cnt !== 8'd2) begin n_fail++; $display("FAIL par_cnt: got %0d expected 2", dig_cnt); end
        tick();
    endtask
`endif

    task automatic test_saturate();
        logic [3:0] frames [5] = '{4'd8, 4'd4, 4'd12, 4'd2, 4'd10};
        rst_n = 1'b0; s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_bits(frames[k], 0, 1'b0);
            s_valid = 1'b0;
            tick(); tick();
            if (k == 2) begin
                n_checks++; if (dig_cnt_l !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_at3: got %0d expected 3", dig_cnt_l); end
            end
        end
        n_checks++; if (dig_cnt_l !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_hold: got %0d expected 3", dig_cnt_l); end
        n_checks++; if (bcd_l !== 4'd5) begin n_fail++; $display("FAIL lsb_bcd: got %0d expected 5", bcd_l); end
        n_checks++; if (dig_cnt !== 8'd3) begin n_fail++; $display("FAIL msb_cnt: got %0d expected 3", dig_cnt); end
        n_checks++; if (bcd !== 4'd2) begin n_fail++; $display("FAIL msb_bcd: got %0d expected 2", bcd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bcd_err();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
`ifdef BCD_RX_PARITY_EN
        test_parity();
`endif
        test_saturate();
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d expected 0", both); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
